butterfly_sc_cache_pingpong: RTL and testbench
==============================================

Name: butterfly_sc_cache_pingpong

Overview:
- Shortcut (residual) cache for the butterfly processor, parametrised in element width, lane count, AXI channel count and maximum sequence length.
- Captures one frame of `cfg_length` input vectors, each holding BE_PARALLELISM lanes, into one of two ping-pong banks.
- Replays each stored frame in order to the shortcut-add stage under a valid/ready handshake.
- One bank can be written while the other is read, so a new frame loads while the previous one drains; the single-bank predecessor could not do this.

Parameters:
- DATA_WIDTH, 16, bits per element (fp16).
- BE_PARALLELISM, 32, lanes per vector.
- CHNL, 8, upstream AXI valid channels.
- MAX_LENGTH, 1024, maximum frame length; must be a power of two.
- AW, $clog2(MAX_LENGTH), localparam, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_length  in  16  frame length; sampled on cfg_start.
- cfg_start  in  1  one-cycle pulse; arms the cache.
- cfg_clear  in  1  synchronous flush back to IDLE.
- wr_vld  in  CHNL  per-channel valid.
- wr_dat  in  DATA_WIDTH*BE_PARALLELISM  vector to cache.
- wr_rdy  out  1  write accept.
- rd_vld  out  1  replay data valid.
- rd_dat  out  DATA_WIDTH*BE_PARALLELISM  replayed vector.
- rd_rdy  in  1  consumer ready.
- frame_done  out  1  pulse on the last replay handshake of a frame.
- busy  out  1  high in RUN.
- err_len  out  1  pulse when cfg_start carries an illegal length.

Behaviour:
- Reset and all interfaces:
  - Clock is clk; reset is rst_n, asynchronous and active-low.
  - Reset forces: wr_rdy=0, rd_vld=0, rd_dat=0, frame_done=0, busy=0, err_len=0, state=IDLE.
  - Reset also clears both bank-full flags, both pointers and the write/read bank selects.
  - Reset asserted mid-frame abandons the frame; bank contents are don't-care.
- State machine:
  - IDLE -> RUN on cfg_start with a legal length: nonzero, <= MAX_LENGTH, power of two.
  - An illegal length pulses err_len for one cycle and stays in IDLE.
  - cfg_start while in RUN is ignored.
  - RUN -> IDLE on cfg_clear. cfg_clear has priority over every other event in the same cycle.
  - Flush clears flags, pointers and rd_vld at the next edge.
- Write side:
  - Accept occurs when &wr_vld && wr_rdy. A partial wr_vld is never accepted.
  - wr_rdy = RUN && !full[wr_bank], computed from registered state only.
  - Each accept writes address wr_ptr in wr_bank.
  - On the accept with wr_ptr == len-1, at that edge: full[wr_bank] sets, wr_ptr returns to 0, and wr_bank toggles.
- Read side:
  - Read uses a synchronous-read bank with one output register.
  - A fetch occurs when full[rd_bank] && (!rd_vld || rd_rdy); rd_ptr then advances.
  - rd_dat/rd_vld hold stable while rd_vld && !rd_rdy.
  - Latency: last write accepted at edge E gives rd_vld=1 after edge E+1, provided the read side is idle.
  - Sustained throughput is one vector per cycle.
- Frame completion:
  - On the handshake of element len-1: full[rd_bank] clears, rd_bank toggles and frame_done pulses.
  - The freed bank is writable from the following cycle, never in the same cycle.
- Boundaries:
  - Both banks full: wr_rdy=0.
  - Both banks empty: rd_vld falls after the last handshake.
  - Frame completion on both sides in the same cycle: both flags update independently and no event is lost.
  - len=1: every accept completes a frame.

Optional Feature:
- Macro: BFLY_SC_CACHE_ERR_EN.
- When defined, adds output err_chnl_cnt [15:0]. It is a saturating count of RUN cycles where wr_vld is nonzero but not all-ones.
- The count clears on reset and on cfg_clear.
- When undefined, the port and the logic are absent; partial valids are silently ignored.

Decomposition:
- Package butterfly_sc_pkg holds:
  - sc_state_e enum {IDLE, RUN}.
  - Function sc_len_legal(len, max).
  - Localparam VEC_W = DATA_WIDTH*BE_PARALLELISM.
- Sub-module butterfly_sc_bank: simple dual-port RAM with depth MAX_LENGTH, width VEC_W and synchronous read, instantiated twice.

Test Plan:
- Reset, then cfg_start with len=256; stream 256 vectors of lane value 16'h3C00+i with rd_rdy=1 -> 256 replay vectors equal in order, and frame_done pulses exactly once, one cycle after the 256th handshake.
- cfg_start with len=100 -> err_len pulses once, busy stays 0, wr_rdy stays 0.
- len=4; write 12 vectors back-to-back with rd_rdy=0 -> wr_rdy drops after the 8th accept; raising rd_rdy resumes writes the cycle after the first frame drains, and all 12 vectors replay in order.
- len=8; rd_rdy toggles every cycle -> rd_dat is stable whenever rd_vld && !rd_rdy, with no duplicated or skipped vectors.
- Mid-frame cfg_clear, and separately mid-frame rst_n=0 -> outputs and flags return to reset values; a new len=16 run then operates correctly.
- With BFLY_SC_CACHE_ERR_EN defined, drive wr_vld=8'h0F for 3 cycles -> err_chnl_cnt=3 and no accept occurs.

Source files
------------

// File: rtl/butterfly_sc_pkg.sv
// Shared types, constants and helpers for the butterfly shortcut (residual) cache.
package butterfly_sc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_e;

    localparam int SC_DATA_WIDTH     = 16;
    localparam int SC_BE_PARALLELISM = 32;
    localparam int VEC_W             = SC_DATA_WIDTH * SC_BE_PARALLELISM;

    // A frame length is usable when it is nonzero, fits the banks and is a power of two.
    function automatic logic sc_len_legal(input logic [15:0] len, input int unsigned max);
        return (len != 16'd0) && (32'(len) <= max) && ((len & (len - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/butterfly_sc_bank.sv
// One ping-pong bank: simple dual-port RAM, synchronous read, resettable output register.
module butterfly_sc_bank #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array write port.
    // NOTE: the array itself is never reset so it can map onto block RAM; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port; a flush zeroes the presented word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_clr) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/butterfly_sc_cache_pingpong.sv
// Ping-pong shortcut cache: one bank loads a frame while the other replays.
// Optional feature macro: BFLY_SC_CACHE_ERR_EN adds err_chnl_cnt (partial-valid cycle counter).
module butterfly_sc_cache_pingpong
    import butterfly_sc_pkg::*;
#(
    parameter int DATA_WIDTH     = SC_DATA_WIDTH,
    parameter int BE_PARALLELISM = SC_BE_PARALLELISM,
    parameter int CHNL           = 8,
    parameter int MAX_LENGTH     = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        cfg_length,
    input  logic                               cfg_start,
    input  logic                               cfg_clear,
    input  logic [CHNL-1:0]                    wr_vld,
    input  logic [DATA_WIDTH*BE_PARALLELISM-1:0] wr_dat,
    output logic                               wr_rdy,
    output logic                               rd_vld,
    output logic [DATA_WIDTH*BE_PARALLELISM-1:0] rd_dat,
    input  logic                               rd_rdy,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               err_len
`ifdef BFLY_SC_CACHE_ERR_EN
    ,
    output logic [15:0]                        err_chnl_cnt
`endif
);

    localparam int AW = $clog2(MAX_LENGTH);
    localparam int VW = DATA_WIDTH * BE_PARALLELISM;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]    state;
    logic [AW-1:0] len_m1;
    logic [1:0]    full;
    logic          wr_bank;
    logic [AW-1:0] wr_ptr;
    logic          rd_bank;   // bank the next fetch reads from
    logic [AW-1:0] rd_ptr;
    logic          rd_src;    // bank that supplied the word now on rd_dat
    logic          rd_last;   // word on rd_dat is the final element of its frame

    logic          wr_acc;
    logic          fetch;
    logic          rd_done;
    logic [1:0]    bank_wr_en;
    logic [1:0]    bank_rd_en;
    logic [VW-1:0] bank_q [2];

    // NOTE: wr_rdy depends only on registered state, so it never loops back through wr_vld.
    assign wr_rdy  = (state == ST_RUN) && !full[wr_bank];
    assign busy    = (state == ST_RUN);
    assign wr_acc  = (&wr_vld) && wr_rdy;
    assign fetch   = full[rd_bank] && (!rd_vld || rd_rdy);
    assign rd_done = rd_vld && rd_rdy && rd_last;
    assign rd_dat  = rd_src ? bank_q[1] : bank_q[0];

    assign bank_wr_en = {wr_acc & wr_bank, wr_acc & ~wr_bank};
    assign bank_rd_en = {fetch & rd_bank, fetch & ~rd_bank};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        butterfly_sc_bank #(
            .DEPTH (MAX_LENGTH),
            .WIDTH (VW),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bank_wr_en[b]),
            .wr_addr (wr_ptr),
            .wr_dat  (wr_dat),
            .rd_en   (bank_rd_en[b]),
            .rd_clr  (cfg_clear),
            .rd_addr (rd_ptr),
            .rd_dat  (bank_q[b])
        );
    end

    // Control FSM: arm on a legal length, report illegal ones, flush on cfg_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            len_m1  <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (cfg_clear) begin
                state <= ST_IDLE;
            end else if ((state == ST_IDLE) && cfg_start) begin
                if (sc_len_legal(cfg_length, MAX_LENGTH)) begin
                    state  <= ST_RUN;
                    len_m1 <= AW'(cfg_length - 16'd1);
                end else begin
                    err_len <= 1'b1;
                end
            end
        end
    end

    // Write pointer and bank select; the last element of a frame hands over to the other bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (cfg_clear) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_acc) begin
            if (wr_ptr == len_m1) begin
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Replay side: fetch ahead into the bank output register, hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            rd_bank    <= 1'b0;
            rd_src     <= 1'b0;
            rd_last    <= 1'b0;
            rd_vld     <= 1'b0;
            frame_done <= 1'b0;
        end else if (cfg_clear) begin
            rd_ptr     <= '0;
            rd_bank    <= 1'b0;
            rd_src     <= 1'b0;
            rd_last    <= 1'b0;
            rd_vld     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= rd_done;
            if (fetch) begin
                rd_vld  <= 1'b1;
                rd_src  <= rd_bank;
                rd_last <= (rd_ptr == len_m1);
                if (rd_ptr == len_m1) begin
                    rd_ptr  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end else if (rd_rdy) begin
                rd_vld <= 1'b0;
            end
        end
    end

    // Bank-full flags: set by write-frame completion, cleared by replay-frame completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else if (cfg_clear) begin
            full <= '0;
        end else begin
            if (wr_acc && (wr_ptr == len_m1)) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_src] <= 1'b0;
            end
        end
    end

`ifdef BFLY_SC_CACHE_ERR_EN
    // Saturating count of RUN cycles that present a partial channel-valid pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chnl_cnt <= '0;
        end else if (cfg_clear) begin
            err_chnl_cnt <= '0;
        end else if ((state == ST_RUN) && (wr_vld != '0) && !(&wr_vld)
                     && (err_chnl_cnt != 16'hFFFF)) begin
            err_chnl_cnt <= err_chnl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_sc_cache_pingpong.sv
// Self-checking bench for butterfly_sc_cache_pingpong: table-driven length checks,
// directed multi-cycle sequences and randomized traffic against a frame-level model.
module tb_butterfly_sc_cache_pingpong;

    localparam int DW = 16;
    localparam int BP = 32;
    localparam int CH = 8;
    localparam int ML = 1024;
    localparam int VW = DW * BP;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        int len;
        bit err;
    } len_vec_t;

    logic          clk;
    logic          rst_n;
    logic [15:0]   cfg_length;
    logic          cfg_start;
    logic          cfg_clear;
    logic [CH-1:0] wr_vld;
    vec_t          wr_dat;
    logic          wr_rdy;
    logic          rd_vld;
    vec_t          rd_dat;
    logic          rd_rdy;
    logic          frame_done;
    logic          busy;
    logic          err_len;
`ifdef BFLY_SC_CACHE_ERR_EN
    logic [15:0]   err_chnl_cnt;
`endif

    butterfly_sc_cache_pingpong #(
        .DATA_WIDTH     (DW),
        .BE_PARALLELISM (BP),
        .CHNL           (CH),
        .MAX_LENGTH     (ML)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_length   (cfg_length),
        .cfg_start    (cfg_start),
        .cfg_clear    (cfg_clear),
        .wr_vld       (wr_vld),
        .wr_dat       (wr_dat),
        .wr_rdy       (wr_rdy),
        .rd_vld       (rd_vld),
        .rd_dat       (rd_dat),
        .rd_rdy       (rd_rdy),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_len      (err_len)
`ifdef BFLY_SC_CACHE_ERR_EN
        ,
        .err_chnl_cnt (err_chnl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame-level model: queue of accepted vectors, frame counters, armed flag.
    bit   running;
    int   m_len;
    int   full_cnt;
    int   wr_cnt;
    int   hs_cnt;
    int   fd_seen;
    int   acc_total;
    int   first_stall;
    int   rd_pol;
    int   wcount;
    vec_t q[$];

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_wr_rdy();
        return running && (full_cnt < 2);
    endfunction

    function automatic bit len_ok(input int l);
        return (l > 0) && (l <= ML) && ($countones(l) == 1);
    endfunction

    task automatic model_reset();
        running  = 1'b0;
        full_cnt = 0;
        wr_cnt   = 0;
        hs_cnt   = 0;
        q.delete();
    endtask

    function automatic vec_t make_vec(input bit ramp);
        vec_t v;
        logic [15:0] lane;
        if (ramp) begin
            lane = 16'h3C00 + 16'(wcount);
            v = {BP{lane}};
        end else begin
            for (int k = 0; k < BP; k++) v[k*DW +: DW] = 16'($urandom);
        end
        return v;
    endfunction

    // One clock: predict from the model, advance, compare registered outputs.
    task automatic tick();
        bit   acc, hs, clr, hold, fd_n, err_n;
        vec_t held, exp_v;
        case (rd_pol)
            1: rd_rdy = ~rd_rdy;
            2: rd_rdy = 1'($urandom_range(0, 1));
            default: ;
        endcase
        clr = cfg_clear;
        check("wr_rdy", {511'b0, wr_rdy}, {511'b0, m_wr_rdy()});
        acc  = !clr && (&wr_vld) && m_wr_rdy();
        hs   = !clr && rd_vld && rd_rdy;
        hold = !clr && rd_vld && !rd_rdy;
        held = rd_dat;
        fd_n = 1'b0;
        err_n = 1'b0;
        if (running && !m_wr_rdy() && first_stall < 0) first_stall = acc_total;
        if (clr) begin
            model_reset();
        end else begin
            if (hs) begin
                check("rd_has_data", {511'b0, q.size() != 0}, 1);
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    check("rd_dat", rd_dat, exp_v);
                end
                hs_cnt++;
                if (hs_cnt == m_len) begin
                    hs_cnt = 0;
                    full_cnt--;
                    fd_n = 1'b1;
                end
            end
            if (acc) begin
                q.push_back(wr_dat);
                acc_total++;
                wr_cnt++;
                if (wr_cnt == m_len) begin
                    wr_cnt = 0;
                    full_cnt++;
                end
            end
            if (cfg_start && !running) begin
                if (len_ok(int'(cfg_length))) begin
                    running = 1'b1;
                    m_len   = int'(cfg_length);
                end else begin
                    err_n = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
        check("frame_done", {511'b0, frame_done}, {511'b0, fd_n});
        check("err_len", {511'b0, err_len}, {511'b0, err_n});
        check("busy", {511'b0, busy}, {511'b0, running});
        if (hold) begin
            check("hold_vld", {511'b0, rd_vld}, 1);
            check("hold_dat", rd_dat, held);
        end
    endtask

    task automatic start(input int l);
        cfg_length = 16'(l);
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic do_clear();
        wr_vld    = '0;
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clr_rd_vld", {511'b0, rd_vld}, 0);
        check("clr_rd_dat", rd_dat, 0);
        check("clr_wr_rdy", {511'b0, wr_rdy}, 0);
    endtask

    task automatic write_n(input int n, input bit ramp, input bit part);
        int   done = 0;
        int   guard = 0;
        bit   taken;
        vec_t v;
        v = make_vec(ramp);
        while (done < n && guard < n * 20 + 100) begin
            wr_dat = v;
            if (part && $urandom_range(0, 3) == 0) wr_vld = CH'($urandom_range(1, 254));
            else wr_vld = '1;
            taken = m_wr_rdy() && (&wr_vld);
            tick();
            if (taken) begin
                done++;
                wcount++;
                v = make_vec(ramp);
            end
            guard++;
        end
        wr_vld = '0;
        if (done < n) check("write_timeout", done, n);
    endtask

    task automatic drain(input int pol, output int cycles);
        rd_pol = pol;
        if (pol == 0) rd_rdy = 1'b1;
        wr_vld = '0;
        cycles = 0;
        while (q.size() != 0 && cycles < 4000) begin
            tick();
            cycles++;
        end
        check("drain_left", q.size(), 0);
        check("rd_vld_idle", {511'b0, rd_vld}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        len_vec_t tv[9];
        int       rl[5];
        int       c;

        tv[0] = '{0, 1};    tv[1] = '{100, 1};  tv[2] = '{1, 0};
        tv[3] = '{1024, 0}; tv[4] = '{1025, 1}; tv[5] = '{2048, 1};
        tv[6] = '{3, 1};    tv[7] = '{512, 0};  tv[8] = '{65535, 1};
        rl = '{1, 2, 4, 8, 32};

        rst_n = 1'b0; cfg_length = '0; cfg_start = 1'b0; cfg_clear = 1'b0;
        wr_vld = '0; wr_dat = '0; rd_rdy = 1'b0; rd_pol = 0;
        model_reset();
        m_len = 1; fd_seen = 0; acc_total = 0; first_stall = -1; wcount = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_rdy", {511'b0, wr_rdy}, 0);
        check("rst_rd_vld", {511'b0, rd_vld}, 0);
        check("rst_rd_dat", rd_dat, 0);
        check("rst_frame_done", {511'b0, frame_done}, 0);
        check("rst_busy", {511'b0, busy}, 0);
        check("rst_err_len", {511'b0, err_len}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Length legality table.
        for (int i = 0; i < 9; i++) begin
            start(tv[i].len);
            check("tbl_err_len", {511'b0, err_len}, {511'b0, tv[i].err});
            check("tbl_busy", {511'b0, busy}, {511'b0, !tv[i].err});
            check("tbl_wr_rdy", {511'b0, wr_rdy}, {511'b0, !tv[i].err});
            if (!tv[i].err) do_clear();
        end

        // len=256 ramp frame, consumer always ready.
        start(256);
        rd_pol = 0; rd_rdy = 1'b1; wcount = 0; fd_seen = 0;
        write_n(256, 1'b1, 1'b0);
        check("lat_after_last_wr", {511'b0, rd_vld}, 0);
        drain(0, c);
        check("drain_cycles_256", c, 257);
        tick();
        check("frame_done_once", fd_seen, 1);
        do_clear();

        // len=4, twelve vectors with the consumer stalled, then released.
        start(4);
        start(100);
        check("run_ignores_start", {511'b0, busy}, 1);
        rd_pol = 0; rd_rdy = 1'b0; first_stall = -1; acc_total = 0;
        write_n(8, 1'b0, 1'b0);
        wr_vld = '1; wr_dat = make_vec(1'b0);
        repeat (3) tick();
        check("both_full_wr_rdy", {511'b0, wr_rdy}, 0);
        check("stall_after_accepts", first_stall, 8);
        rd_rdy = 1'b1;
        write_n(4, 1'b0, 1'b0);
        drain(0, c);
        check("accepts_total", acc_total, 12);
        do_clear();

        // len=8, consumer ready toggles every cycle.
        start(8);
        rd_pol = 1;
        write_n(24, 1'b0, 1'b0);
        drain(1, c);
        rd_pol = 0;
        do_clear();

        // Mid-frame flush, then a fresh len=16 run.
        start(16);
        rd_pol = 0; rd_rdy = 1'b0;
        write_n(19, 1'b0, 1'b0);
        check("pre_clr_rd_vld", {511'b0, rd_vld}, 1);
        do_clear();
        check("clr_busy", {511'b0, busy}, 0);
        start(16);
        rd_rdy = 1'b1;
        write_n(32, 1'b0, 1'b0);
        drain(0, c);
        do_clear();

        // Mid-frame asynchronous reset, then a fresh len=16 run.
        start(16);
        rd_rdy = 1'b0;
        write_n(20, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_wr_rdy", {511'b0, wr_rdy}, 0);
        check("mid_rst_rd_vld", {511'b0, rd_vld}, 0);
        check("mid_rst_rd_dat", rd_dat, 0);
        check("mid_rst_busy", {511'b0, busy}, 0);
        check("mid_rst_frame_done", {511'b0, frame_done}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start(16);
        rd_rdy = 1'b1;
        write_n(48, 1'b0, 1'b0);
        drain(0, c);
        do_clear();

        // Randomized traffic: partial valids and random consumer stalls.
        for (int i = 0; i < 5; i++) begin
            start(rl[i]);
            rd_pol = 2;
            write_n(rl[i] * int'($urandom_range(2, 5)), 1'b0, 1'b1);
            drain(2, c);
            rd_pol = 0;
            do_clear();
        end

`ifdef BFLY_SC_CACHE_ERR_EN
        start(4);
        rd_rdy = 1'b1;
        wr_vld = 8'h0F; wr_dat = make_vec(1'b0);
        repeat (3) tick();
        wr_vld = '0;
        check("err_chnl_cnt", err_chnl_cnt, 3);
        check("partial_no_accept", q.size(), 0);
        do_clear();
        check("err_chnl_cnt_clr", err_chnl_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
